beep_sequencer: RTL and testbench
=================================

# beep_sequencer

Turns a requested beep rate into a gated audible tone for the piezo buzzer on the lift tool. It sits between level/distance classification logic, which drives `rate_sel`, and the buzzer pin. Beep periods are generated internally from the system clock, and rate changes are applied glitch-free at beep-period boundaries.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency
- `TONE_HZ`, 2_000, buzzer tone frequency while a beep is sounding
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `rate_sel`  in  3  requested rate: 0 silent, 1 = 2/s, 2 = 3/s, 3 = 4/s, 4 = 8/s, 5 continuous, 6–7 treated as silent
- `buzzer`  out  1  tone square wave, gated by beep window
- `beep_active`  out  1  high while in a sounding window
- `beep_start`  out  1  one-cycle pulse on the first cycle of every beep or continuous run
- `cur_rate`  out  3  rate code currently being executed

## Operation
- Per-rate period: `P = CLK_HZ / N` with integer division, where N is beeps per second. ON length is `P/2` (floor). OFF length is `P - P/2`.
- Tone half-period: `H = CLK_HZ / (2*TONE_HZ)`.
- FSM states are IDLE, ON, OFF and CONT.
- IDLE:
  - Samples `rate_sel` every cycle.
  - Codes 1–4: go to ON, latch the rate into `cur_rate`, clear the period counter to 0.
  - Code 5: go to CONT.
  - Codes 0, 6, 7: stay in IDLE.
- ON: the period counter increments each cycle. At `cnt == P/2 - 1` the FSM goes to OFF.
- OFF: the counter continues. At `cnt == P-1` the FSM resamples `rate_sel` exactly as IDLE does (1–4 → ON with counter 0; 5 → CONT; silent → IDLE).
- CONT: any code other than 5 → IDLE on the next cycle. A beeping code then re-enters ON one cycle later.
- Silence abort: `rate_sel` ∈ {0, 6, 7} sampled in ON or OFF forces IDLE on the next cycle. The current period is truncated.
- Changes between codes 1–5 during ON/OFF take effect only at the period boundary; the latched `cur_rate` governs until then.
- Tone phase counter:
  - Reloads at every entry to ON or CONT, so each beep starts with the tone high.
  - Toggles the tone every H cycles.
- `buzzer = tone & beep_active`.
- `beep_active` is high in ON and CONT.
- `cur_rate` is 0 in IDLE.

## Timing
- Reset values: state IDLE, `buzzer`=0, `beep_active`=0, `beep_start`=0, `cur_rate`=0. All counters are 0.
- Reset mid-beep silences `buzzer` immediately (asynchronous) and restarts from IDLE.
- All outputs are registered.
- IDLE → first sound: with `rate_sel` sampled at edge t, `beep_active`, `beep_start` and `buzzer` are all 1 after edge t+1.
- Silence latency: `buzzer` is 0 one cycle after the silent code is sampled.
- Beep-to-beep spacing equals exactly P cycles at a steady rate.
- `beep_start` is asserted only on the cycle of entry to ON or CONT, never in steady CONT.
- Counter width is `$clog2(CLK_HZ/2)`, with no wrap inside a period.

## Configuration
- `BEEP_COUNT_EN`:
  - Defined: adds output `beep_count` [15:0]. It increments on every `beep_start`, saturates at 16'hFFFF, and resets to 0.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `beep_pkg`:
  - Rate code localparams (`RATE_SILENT` … `RATE_CONT`).
  - FSM state enum.
  - Function `period_cycles(rate, clk_hz)` returning P.
- Sub-module `tone_gen`:
  - Inputs: `clk`, `rst`, synchronous `restart`.
  - Parameter: H.
  - Output: square wave.
  - Instantiated once.

## Test plan
Sim parameters: CLK_HZ=1000, TONE_HZ=100, so H=5.
- `rate_sel`=1 from reset release → `beep_start` pulses every 500 cycles; `beep_active` high for 250 cycles then low for 250; `buzzer` toggles every 5 cycles inside the window.
- `rate_sel`=2 → P=333, ON=166, OFF=167. Check the exact counts over 3 periods.
- Steady rate 1; switch to 4 at cycle 100 of a period → the old period completes at 500; the next beeps are 125 cycles apart with ON=62.
- Rate 3 mid-ON; drive 0 → `buzzer` and `beep_active` are 0 one cycle later; `cur_rate`=0; no further `beep_start`.
- `rate_sel`=5 → one `beep_start` pulse, then continuous tone; switch to 1 → one IDLE cycle, then a new `beep_start`.
- Assert `rst` mid-beep → all outputs 0 without a clock edge. With `BEEP_COUNT_EN`: 3 beeps give `beep_count`=3, and reset returns it to 0.

Source files
------------

// File: rtl/beep_pkg.sv
// beep_pkg: shared definitions for the beep sequencer.
//   - rate codes carried on rate_sel / cur_rate
//   - FSM state encoding
//   - period_cycles(): clock cycles in one beep period for a rate code
//   - is_beep_rate(): true for the periodic (non-continuous) beep codes
package beep_pkg;

  localparam logic [2:0] RATE_SILENT = 3'd0;
  localparam logic [2:0] RATE_2HZ    = 3'd1;
  localparam logic [2:0] RATE_3HZ    = 3'd2;
  localparam logic [2:0] RATE_4HZ    = 3'd3;
  localparam logic [2:0] RATE_8HZ    = 3'd4;
  localparam logic [2:0] RATE_CONT   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_CONT = 2'd3
  } state_e;

  // Beep period in cycles, integer division by beeps per second.
  // Non-beeping codes return the slowest period so callers never see zero.
  function automatic int unsigned period_cycles(input logic [2:0] rate,
                                                input int unsigned clk_hz);
    case (rate)
      RATE_2HZ: return clk_hz / 2;
      RATE_3HZ: return clk_hz / 3;
      RATE_4HZ: return clk_hz / 4;
      RATE_8HZ: return clk_hz / 8;
      default:  return clk_hz / 2;
    endcase
  endfunction

  function automatic logic is_beep_rate(input logic [2:0] rate);
    return (rate >= RATE_2HZ) && (rate <= RATE_8HZ);
  endfunction

endpackage

// File: rtl/tone_gen.sv
// tone_gen: square-wave tone generator.
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   restart - synchronous restart; the tone is high for the first
//             HALF_PERIOD cycles after the edge that samples it
//   tone    - square wave, toggles every HALF_PERIOD cycles
module tone_gen #(
  parameter int unsigned HALF_PERIOD = 12_500
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tone
);

  localparam int unsigned TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [TW-1:0] LAST = TW'(HALF_PERIOD - 1);

  logic [TW-1:0] phase_q, phase_d;
  logic          tone_q, tone_d;

  // Restart wins over the free-running phase so every beep begins high.
  always_comb begin
    phase_d = phase_q;
    tone_d  = tone_q;
    if (restart) begin
      phase_d = '0;
      tone_d  = 1'b1;
    end else if (phase_q == LAST) begin
      phase_d = '0;
      tone_d  = ~tone_q;
    end else begin
      phase_d = phase_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      tone_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      tone_q  <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/beep_sequencer.sv
// beep_sequencer: turns a requested beep rate into a gated buzzer tone.
// Ports:
//   clk         - system clock (CLK_HZ)
//   rst         - asynchronous active-high reset
//   rate_sel    - requested rate code (0 silent, 1..4 periodic, 5 continuous,
//                 6..7 silent)
//   buzzer      - tone gated by the sounding window (registered)
//   beep_active - high while sounding (registered)
//   beep_start  - one-cycle pulse on the first cycle of each beep or
//                 continuous run (registered)
//   cur_rate    - rate code currently executing, 0 when idle (registered)
//   beep_count  - saturating count of beep_start pulses; present only when
//                 the BEEP_COUNT_EN macro is defined
module beep_sequencer
  import beep_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TONE_HZ = 2_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] rate_sel,
  output logic       buzzer,
  output logic       beep_active,
  output logic       beep_start,
  output logic [2:0] cur_rate
`ifdef BEEP_COUNT_EN
  ,
  output logic [15:0] beep_count
`endif
);

  localparam int unsigned CW       = $clog2(CLK_HZ / 2);
  localparam int unsigned HALF_TON = CLK_HZ / (2 * TONE_HZ);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    rate_q, rate_d;
  logic          enter_q, enter_d;

  int unsigned   period;
  logic [CW-1:0] on_last, period_last;
  logic          silent;
  logic          sounding;
  logic          tone;

  logic          buzzer_q, active_q, start_q;
  logic [2:0]    cur_rate_q;

  // Compare constants are formed in int width and then narrowed, so a period
  // of exactly 2**CW cycles still yields an in-range last count.
  always_comb begin
    period      = period_cycles(rate_q, CLK_HZ);
    on_last     = CW'(period / 2 - 1);
    period_last = CW'(period - 1);
    silent      = !(is_beep_rate(rate_sel) || (rate_sel == RATE_CONT));
  end

  // Next-state logic. Rate changes between audible codes are only honoured
  // at the period boundary; silence aborts the period immediately.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rate_d  = rate_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (is_beep_rate(rate_sel)) begin
          state_d = ST_ON;
          rate_d  = rate_sel;
        end else if (rate_sel == RATE_CONT) begin
          state_d = ST_CONT;
          rate_d  = RATE_CONT;
        end else begin
          rate_d  = RATE_SILENT;
        end
      end
      ST_ON: begin
        if (silent) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          rate_d  = RATE_SILENT;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == on_last) state_d = ST_OFF;
        end
      end
      ST_OFF: begin
        if (silent) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          rate_d  = RATE_SILENT;
        end else if (cnt_q == period_last) begin
          cnt_d = '0;
          if (is_beep_rate(rate_sel)) begin
            state_d = ST_ON;
            rate_d  = rate_sel;
          end else begin
            state_d = ST_CONT;
            rate_d  = RATE_CONT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CONT: begin
        cnt_d = '0;
        if (rate_sel != RATE_CONT) begin
          state_d = ST_IDLE;
          rate_d  = RATE_SILENT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rate_d  = RATE_SILENT;
      end
    endcase
    enter_d = ((state_d == ST_ON)   && (state_q != ST_ON)) ||
              ((state_d == ST_CONT) && (state_q != ST_CONT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rate_q  <= RATE_SILENT;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rate_q  <= rate_d;
      enter_q <= enter_d;
    end
  end

  // The tone restarts on the same edge the FSM enters a sounding state, so it
  // is high during the first sounding cycle.
  tone_gen #(
    .HALF_PERIOD(HALF_TON)
  ) u_tone (
    .clk    (clk),
    .rst    (rst),
    .restart(enter_d),
    .tone   (tone)
  );

  assign sounding = (state_q == ST_ON) || (state_q == ST_CONT);

  // Output stage: every output is a flop fed from the state-domain signals,
  // which keeps the buzzer pin glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buzzer_q   <= 1'b0;
      active_q   <= 1'b0;
      start_q    <= 1'b0;
      cur_rate_q <= RATE_SILENT;
    end else begin
      buzzer_q   <= tone & sounding;
      active_q   <= sounding;
      start_q    <= enter_q;
      cur_rate_q <= rate_q;
    end
  end

  assign buzzer      = buzzer_q;
  assign beep_active = active_q;
  assign beep_start  = start_q;
  assign cur_rate    = cur_rate_q;

`ifdef BEEP_COUNT_EN
  logic [15:0] count_q, count_d;

  // Counts on the edge that raises beep_start, so the count already includes
  // a pulse while that pulse is visible.
  always_comb begin
    count_d = count_q;
    if (enter_q && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= 16'd0;
    else     count_q <= count_d;
  end

  assign beep_count = count_q;
`endif

endmodule

// File: tb/tb_beep_sequencer.sv
// tb_beep_sequencer: directed self-checking bench for beep_sequencer, run
// with CLK_HZ=1000 and TONE_HZ=100 (tone half-period 5 cycles).
// Checks the beep_count port as well when BEEP_COUNT_EN is defined.
module tb_beep_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] rate_sel;
  logic       buzzer;
  logic       beep_active;
  logic       beep_start;
  logic [2:0] cur_rate;
`ifdef BEEP_COUNT_EN
  logic [15:0] beep_count;
`endif

  int compared;
  int mismatched;
  int steps;
  int aCnt, sCnt, hCnt, tCnt;

  beep_sequencer #(
    .CLK_HZ (1000),
    .TONE_HZ(100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rate_sel   (rate_sel),
    .buzzer     (buzzer),
    .beep_active(beep_active),
    .beep_start (beep_start),
    .cur_rate   (cur_rate)
`ifdef BEEP_COUNT_EN
    ,
    .beep_count (beep_count)
`endif
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls well beyond the directed sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance n clock edges and land 1 time unit after the last one.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitStart(input int limit, output int taken);
    taken = 0;
    while (beep_start !== 1'b1 && taken < limit) begin
      applyStimulus(1);
      taken++;
    end
  endtask

  // Observes n consecutive samples; sample 0 is the current one.
  task automatic sampleWindow(input int n, output int activeN, output int startN,
                              output int highN, output int toggleN);
    logic prevBuz;
    activeN = 0;
    startN  = 0;
    highN   = 0;
    toggleN = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        prevBuz = buzzer;
        applyStimulus(1);
        if (buzzer !== prevBuz) toggleN++;
      end
      if (beep_active === 1'b1) activeN++;
      if (beep_start === 1'b1)  startN++;
      if (buzzer === 1'b1)      highN++;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    rate_sel   = 3'd1;
    applyStimulus(3);

    checkOutput("reset_buzzer", 32'(buzzer), 32'd0);
    checkOutput("reset_active", 32'(beep_active), 32'd0);
    checkOutput("reset_start", 32'(beep_start), 32'd0);
    checkOutput("reset_cur_rate", 32'(cur_rate), 32'd0);
`ifdef BEEP_COUNT_EN
    checkOutput("reset_count", 32'(beep_count), 32'd0);
`endif

    // Rate 1: P=500, ON=250, tone toggles every 5 cycles
    rst = 1'b0;
    waitStart(10, steps);
    checkOutput("first_sound_latency", steps, 2);
    checkOutput("first_buzzer", 32'(buzzer), 32'd1);
    checkOutput("first_active", 32'(beep_active), 32'd1);
    checkOutput("first_cur_rate", 32'(cur_rate), 32'd1);
    sampleWindow(500, aCnt, sCnt, hCnt, tCnt);
    checkOutput("r1_on_cycles", aCnt, 250);
    checkOutput("r1_starts", sCnt, 1);
    checkOutput("r1_buzzer_high", hCnt, 125);
    checkOutput("r1_buzzer_toggles", tCnt, 49);
    applyStimulus(1);
    checkOutput("r1_spacing", 32'(beep_start), 32'd1);

    // Switch to rate 4 at cycle 100; old period still completes at 500
    applyStimulus(100);
    rate_sel = 3'd4;
    sampleWindow(400, aCnt, sCnt, hCnt, tCnt);
    checkOutput("sw_old_on_rest", aCnt, 150);
    checkOutput("sw_no_early_start", sCnt, 0);
    checkOutput("sw_old_rate_held", 32'(cur_rate), 32'd1);
    applyStimulus(1);
    checkOutput("sw_boundary_start", 32'(beep_start), 32'd1);
    checkOutput("sw_new_rate", 32'(cur_rate), 32'd4);
    sampleWindow(125, aCnt, sCnt, hCnt, tCnt);
    checkOutput("r4_on_cycles", aCnt, 62);
    checkOutput("r4_starts", sCnt, 1);
    checkOutput("r4_buzzer_high", hCnt, 32);
    applyStimulus(1);
    checkOutput("r4_spacing", 32'(beep_start), 32'd1);

    // Rate 2: P=333, ON=166, OFF=167, over three periods
    rate_sel = 3'd2;
    sampleWindow(125, aCnt, sCnt, hCnt, tCnt);
    checkOutput("r4_second_on", aCnt, 62);
    applyStimulus(1);
    checkOutput("r2_start", 32'(beep_start), 32'd1);
    checkOutput("r2_cur_rate", 32'(cur_rate), 32'd2);
    sampleWindow(999, aCnt, sCnt, hCnt, tCnt);
    checkOutput("r2_on_cycles", aCnt, 498);
    checkOutput("r2_starts", sCnt, 3);
    checkOutput("r2_buzzer_high", hCnt, 255);
    applyStimulus(1);
    checkOutput("r2_spacing", 32'(beep_start), 32'd1);

    // Rate 3, then silence mid-ON
    rate_sel = 3'd3;
    sampleWindow(333, aCnt, sCnt, hCnt, tCnt);
    applyStimulus(1);
    checkOutput("r3_start", 32'(beep_start), 32'd1);
    checkOutput("r3_cur_rate", 32'(cur_rate), 32'd3);
    applyStimulus(50);
    checkOutput("r3_mid_on", 32'(beep_active), 32'd1);
    rate_sel = 3'd0;
    applyStimulus(1);
    checkOutput("silence_sample_edge", 32'(beep_active), 32'd1);
    applyStimulus(1);
    checkOutput("silence_active", 32'(beep_active), 32'd0);
    checkOutput("silence_buzzer", 32'(buzzer), 32'd0);
    checkOutput("silence_cur_rate", 32'(cur_rate), 32'd0);
    sampleWindow(600, aCnt, sCnt, hCnt, tCnt);
    checkOutput("silence_no_start", sCnt, 0);
    checkOutput("silence_no_active", aCnt, 0);

    // Continuous, then back to rate 1 through one IDLE cycle
    rate_sel = 3'd5;
    applyStimulus(1);
    checkOutput("cont_latency", 32'(beep_start), 32'd0);
    applyStimulus(1);
    checkOutput("cont_start", 32'(beep_start), 32'd1);
    checkOutput("cont_buzzer", 32'(buzzer), 32'd1);
    checkOutput("cont_cur_rate", 32'(cur_rate), 32'd5);
    sampleWindow(300, aCnt, sCnt, hCnt, tCnt);
    checkOutput("cont_active", aCnt, 300);
    checkOutput("cont_single_start", sCnt, 1);
    checkOutput("cont_buzzer_high", hCnt, 150);
    rate_sel = 3'd1;
    applyStimulus(1);
    checkOutput("cont_exit_edge", 32'(beep_active), 32'd1);
    applyStimulus(1);
    checkOutput("cont_idle_gap", 32'(beep_active), 32'd0);
    checkOutput("cont_idle_rate", 32'(cur_rate), 32'd0);
    applyStimulus(1);
    checkOutput("cont_to_r1_start", 32'(beep_start), 32'd1);
    checkOutput("cont_to_r1_rate", 32'(cur_rate), 32'd1);

    // Asynchronous reset mid-beep
    applyStimulus(10);
    checkOutput("pre_reset_buzzer", 32'(buzzer), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_buzzer", 32'(buzzer), 32'd0);
    checkOutput("async_rst_active", 32'(beep_active), 32'd0);
    checkOutput("async_rst_cur_rate", 32'(cur_rate), 32'd0);
    applyStimulus(2);

`ifdef BEEP_COUNT_EN
    rate_sel = 3'd4;
    rst = 1'b0;
    waitStart(10, steps);
    applyStimulus(1);
    waitStart(200, steps);
    applyStimulus(1);
    waitStart(200, steps);
    checkOutput("count_three", 32'(beep_count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("count_reset", 32'(beep_count), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
